// File: rtl/key_event_fifo.sv
// key_event_fifo: show-ahead event FIFO between the keyboard scanner
// (producer) and the SPI reply path (consumer). When the FIFO is full and
// no pop happens in the same cycle, a pushed event is dropped and the sticky
// overflow flag is set.
module key_event_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Flags come only from the registered count, so wr_en/rd_en never
    // reach empty/full combinationally.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);

    // A push into a full FIFO is still accepted if a pop frees a slot in the
    // same cycle. A pop on an empty FIFO is ignored.
    assign w_push = wr_en && (!w_full || rd_en);
    assign w_pop  = rd_en && !w_empty;
    assign w_drop = wr_en && w_full && !rd_en;

    // Storage array: written on accepted pushes only, never reset (stale
    // contents are unreachable once the pointers and count are cleared).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear leaves it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Show-ahead head of queue; forced to zero while empty (including reset).
    always_comb begin
        rd_data = '0;
        if (!w_empty) begin
            rd_data = r_mem[r_rd_ptr];
        end
    end

    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_key_event_fifo.sv
// Testbench for key_event_fifo: directed scenarios plus randomized traffic,
// compared against a queue-based model of the FIFO.
module tb_key_event_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr;

    int n_vec;
    int n_err;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_ovf;

    key_event_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic chk_all(input string tag);
        logic [7:0] head;
        head = (mq.size() == 0) ? 8'h00 : mq[0];
        chk({tag, ".count"},    32'(count),    32'(mq.size()));
        chk({tag, ".empty"},    32'(empty),    32'(mq.size() == 0));
        chk({tag, ".full"},     32'(full),     32'(mq.size() == 16));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".rd_data"},  32'(rd_data),  32'(head));
    endtask

    // Model of one clock edge, from the FIFO's behavioural rules.
    task automatic model_edge(input logic we, input logic [7:0] wd, input logic re, input logic clr);
        bit was_full;
        bit was_empty;
        was_full  = (mq.size() == 16);
        was_empty = (mq.size() == 0);
        if (re && !was_empty) void'(mq.pop_front());
        if (we && (!was_full || re)) mq.push_back(wd);
        if (we && was_full && !re) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    // Drive inputs now, take one rising edge, check 1ns later.
    task automatic drive_edge(input string tag, input logic we, input logic [7:0] wd,
                              input logic re, input logic clr);
        wr_en = we; wr_data = wd; rd_en = re; ovf_clr = clr;
        @(posedge clk);
        model_edge(we, wd, re, clr);
        #1;
        chk_all(tag);
    endtask

    task automatic step(input string tag, input logic we, input logic [7:0] wd,
                        input logic re, input logic clr);
        @(negedge clk);
        drive_edge(tag, we, wd, re, clr);
    endtask

    initial begin
        logic [7:0] d;
        n_vec = 0; n_err = 0; m_ovf = 1'b0;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; ovf_clr = 1'b0;

        // Reset state
        #12;
        chk_all("reset_init");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("reset_release");

        // Order: 0x11, 0x22, 0x33 then three pops
        step("ord_push1", 1'b1, 8'h11, 1'b0, 1'b0);
        chk("ord_first_visible", 32'(rd_data), 32'h11);
        step("ord_push2", 1'b1, 8'h22, 1'b0, 1'b0);
        step("ord_push3", 1'b1, 8'h33, 1'b0, 1'b0);
        chk("ord_head0", 32'(rd_data), 32'h11);
        step("ord_pop1", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("ord_head1", 32'(rd_data), 32'h22);
        step("ord_pop2", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("ord_head2", 32'(rd_data), 32'h33);
        step("ord_pop3", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("ord_empty", 32'(empty), 32'h1);
        chk("ord_rd0", 32'(rd_data), 32'h00);
        step("pop_on_empty", 1'b0, 8'h00, 1'b1, 1'b0);

        // Full and overflow: 17 pushes 0x01..0x11, no pops
        for (int i = 1; i <= 17; i++) step("fill17", 1'b1, 8'(i), 1'b0, 1'b0);
        chk("ovf_full", 32'(full), 32'h1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'h1);
        for (int i = 1; i <= 16; i++) begin
            chk("ovf_pop_val", 32'(rd_data), 32'(i));
            step("ovf_pop", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("ovf_drained", 32'(empty), 32'h1);
        step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'h0);

        // Simultaneous push/pop while full
        for (int i = 0; i < 16; i++) step("sim_fill", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        step("sim_full_rw", 1'b1, 8'hAA, 1'b1, 1'b0);
        chk("sim_count16", 32'(count), 32'd16);
        chk("sim_no_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 15; i++) step("sim_drain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("sim_last_aa", 32'(rd_data), 32'hAA);
        step("sim_drain_last", 1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous push/pop while empty
        step("emp_rw", 1'b1, 8'h5C, 1'b1, 1'b0);
        chk("emp_count1", 32'(count), 32'd1);
        chk("emp_rd5c", 32'(rd_data), 32'h5C);
        step("emp_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        // Wrap: preload 3, then 40 push/pop pairs with random data
        for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step("wrap_pair", 1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
        // Random mixed traffic
        for (int i = 0; i < 120; i++)
            step("rand_mix", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));

        // Fill, then clear and drop in the same cycle: set wins
        while (mq.size() < 16) step("clr_fill", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        step("clr_pre_clear", 1'b0, 8'h00, 1'b0, 1'b1);
        step("clr_and_drop", 1'b1, 8'hEE, 1'b0, 1'b1);
        chk("clr_set_wins", 32'(overflow), 32'h1);

        // Asynchronous reset mid-cycle with 5 events stored
        while (mq.size() > 0) step("rst_drain", 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step("rst_fill5", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("rst_have5", 32'(count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_empty", 32'(empty), 32'h1);
        chk("rst_async_count", 32'(count), 32'd0);
        chk("rst_async_rd", 32'(rd_data), 32'h00);
        chk("rst_async_full", 32'(full), 32'h0);
        chk("rst_async_ovf", 32'(overflow), 32'h0);
        mq.delete();
        m_ovf = 1'b0;

        // Push accepted on the first edge after release
        @(negedge clk);
        rst = 1'b0;
        drive_edge("post_rst_push", 1'b1, 8'h7E, 1'b0, 1'b0);
        chk("post_rst_rd", 32'(rd_data), 32'h7E);
        step("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
